// File: rtl/result_stream_fifo.sv
// ---------------------------------------------------------------------------
// result_stream_fifo
//
// Captures qualified (addr, data) result pairs from the ASIP store path into
// a DEPTH-entry FIFO and drains them to a host / text-dump consumer over a
// valid/ready handshake. This replaces the old single-cycle {addr, data}
// output strobe. It adds zero-filtering, overflow accounting with a
// saturating drop counter, and a synchronous flush.
//
// Optional build macro:
//   RESULT_STREAM_DEDUP_EN - discard a qualified pair that equals the last
//                            captured pair (no push, no drop count).
//
// Ports:
//   clk        in   single clock, rising edge
//   reset      in   asynchronous, active-low reset
//   in_valid   in   producer write qualifier (memory-stage store enable)
//   in_addr    in   [ADDR_W]  result address
//   in_data    in   [DATA_W]  result data
//   flush      in   synchronous clear of contents and drop counter
//   out_data   out  [ADDR_W+DATA_W] registered head entry {addr, data}
//   out_valid  out  head entry valid
//   out_ready  in   consumer accepts head this cycle
//   level      out  [$clog2(DEPTH)+1] current occupancy
//   full       out  level == DEPTH
//   drop_count out  [CNT_W] pairs lost to overflow, saturating
// ---------------------------------------------------------------------------
module result_stream_fifo #(
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 48,
   parameter int DEPTH       = 8,
   parameter int FILTER_ZERO = 1,
   parameter int CNT_W       = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   input  logic [ADDR_W-1:0]          in_addr,
   input  logic [DATA_W-1:0]          in_data,
   input  logic                       flush,
   output logic [ADDR_W+DATA_W-1:0]   out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       full,
   output logic [CNT_W-1:0]           drop_count
);

   localparam int PW    = $clog2(DEPTH);
   localparam int LVL_W = PW + 1;
   localparam int ENT_W = ADDR_W + DATA_W;

   // Storage and pointers. Pointers carry one extra wrap bit so that
   // full and empty are distinguishable with equal low bits.
   logic [ENT_W-1:0] mem_q [DEPTH];
   logic [PW:0]      wr_ptr_q, wr_ptr_d;
   logic [PW:0]      rd_ptr_q, rd_ptr_d;
   logic [ENT_W-1:0] head_q, head_d;
   logic [CNT_W-1:0] drop_q, drop_d;

   logic [ENT_W-1:0] in_pair;
   logic [PW-1:0]    wr_idx, rd_idx, rd_nxt_idx;
   logic [LVL_W-1:0] level_w;
   logic             empty_w, full_w;
   logic             qual, dup, cap, push, pop, drop;

   assign in_pair    = {in_addr, in_data};
   assign wr_idx     = wr_ptr_q[PW-1:0];
   assign rd_idx     = rd_ptr_q[PW-1:0];
   assign rd_nxt_idx = rd_idx + 1'b1;
   assign level_w    = wr_ptr_q - rd_ptr_q;
   assign empty_w    = (wr_ptr_q == rd_ptr_q);
   assign full_w     = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                       (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

   // Zero filter: a pair with a null address or null data is not a result.
   always_comb begin
      qual = in_valid;
      if (FILTER_ZERO != 0) qual = in_valid && (|in_addr) && (|in_data);
   end

`ifdef RESULT_STREAM_DEDUP_EN
   // Last captured pair. It survives a pop, so a repeat is still caught
   // after the original has been drained.
   logic [ENT_W-1:0] last_q;
   logic             last_vld_q;

   assign dup = last_vld_q && (in_pair == last_q);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_q     <= '0;
         last_vld_q <= 1'b0;
      end else if (flush) begin
         last_q     <= '0;
         last_vld_q <= 1'b0;
      end else if (qual && !dup) begin
         last_q     <= in_pair;
         last_vld_q <= 1'b1;
      end
   end
`else
   assign dup = 1'b0;
`endif

   assign cap  = qual && !dup;
   assign pop  = !empty_w && out_ready;
   // A full FIFO still accepts a pair when the head leaves the same cycle.
   assign push = cap && (!full_w || pop);
   assign drop = cap && full_w && !pop;

   always_comb begin
      wr_ptr_d = wr_ptr_q + LVL_W'(push);
      rd_ptr_d = rd_ptr_q + LVL_W'(pop);

      // Head register tracks mem[rd_ptr]. When the last stored entry leaves
      // while a new one arrives, the new pair becomes the head directly,
      // since it is not yet in the array.
      head_d = head_q;
      if (pop) begin
         if (level_w == LVL_W'(1)) head_d = push ? in_pair : '0;
         else                      head_d = mem_q[rd_nxt_idx];
      end else if (empty_w && push) begin
         head_d = in_pair;
      end

      drop_d = drop_q;
      if (drop && (drop_q != {CNT_W{1'b1}})) drop_d = drop_q + 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         head_q   <= '0;
         drop_q   <= '0;
      end else if (flush) begin
         // Flush wins over any push or pop in the same cycle.
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         head_q   <= '0;
         drop_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         head_q   <= head_d;
         drop_q   <= drop_d;
      end
   end

   // Storage array needs no reset; only entries between the pointers are read.
   always_ff @(posedge clk) begin
      if (push && !flush) mem_q[wr_idx] <= in_pair;
   end

   assign out_data   = head_q;
   assign out_valid  = !empty_w;
   assign level      = level_w;
   assign full       = full_w;
   assign drop_count = drop_q;

endmodule

// File: tb/tb_result_stream_fifo.sv
module tb_result_stream_fifo;

   localparam int AW = 16;
   localparam int DW = 48;
   localparam int CW = 8;

   typedef struct {
      logic        iv;
      logic [15:0] a;
      logic [47:0] d;
      logic        fl;
      logic        rdy;
      logic        ev;
      logic [63:0] ed;
      logic [3:0]  el;
      logic [7:0]  edc;
      string       nm;
   } vec_t;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          in_valid = 1'b0;
   logic          flush = 1'b0;
   logic          out_ready = 1'b0;
   logic [AW-1:0] in_addr = '0;
   logic [DW-1:0] in_data = '0;

   logic [AW+DW-1:0] out_data, nf_data;
   logic             out_valid, nf_valid, full, nf_full;
   logic [3:0]       level, nf_level;
   logic [CW-1:0]    drop_count, nf_drop;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   result_stream_fifo u_dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_addr(in_addr),
      .in_data(in_data), .flush(flush), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready), .level(level),
      .full(full), .drop_count(drop_count)
   );

   result_stream_fifo #(.FILTER_ZERO(0)) u_nf (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_addr(in_addr),
      .in_data(in_data), .flush(flush), .out_data(nf_data),
      .out_valid(nf_valid), .out_ready(out_ready), .level(nf_level),
      .full(nf_full), .drop_count(nf_drop)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic iv, input logic [15:0] a, input logic [47:0] d,
                      input logic fl, input logic rdy);
      in_valid  = iv;
      in_addr   = a;
      in_data   = d;
      flush     = fl;
      out_ready = rdy;
   endtask

   task automatic chk_out(input string nm, input logic ev, input logic [63:0] ed,
                          input logic [3:0] el, input logic [7:0] edc);
      chk({nm, "_valid"}, 64'(out_valid), 64'(ev));
      chk({nm, "_data"},  out_data, ed);
      chk({nm, "_level"}, 64'(level), 64'(el));
      chk({nm, "_full"},  64'(full), 64'(el == 4'd8));
      chk({nm, "_drop"},  64'(drop_count), 64'(edc));
   endtask

   function automatic vec_t mk(logic iv, logic [15:0] a, logic [47:0] d, logic fl,
                               logic rdy, logic ev, logic [63:0] ed, logic [3:0] el,
                               logic [7:0] edc, string nm);
      vec_t v;
      v.iv = iv; v.a = a; v.d = d; v.fl = fl; v.rdy = rdy;
      v.ev = ev; v.ed = ed; v.el = el; v.edc = edc; v.nm = nm;
      return v;
   endfunction

   vec_t        tab [10];
   logic [63:0] got [$];
   logic [63:0] e;

   initial begin
      tab[0] = mk(1, 16'h0010, 48'h1, 0, 0, 1, 64'h0010_000000000001, 4'd1, 8'd0, "ord_push1");
      tab[1] = mk(1, 16'h0020, 48'h2, 0, 0, 1, 64'h0010_000000000001, 4'd2, 8'd0, "ord_push2");
      tab[2] = mk(1, 16'h0030, 48'h3, 0, 0, 1, 64'h0010_000000000001, 4'd3, 8'd0, "ord_push3");
      tab[3] = mk(0, 16'h0000, 48'h0, 0, 1, 1, 64'h0020_000000000002, 4'd2, 8'd0, "ord_pop1");
      tab[4] = mk(0, 16'h0000, 48'h0, 0, 1, 1, 64'h0030_000000000003, 4'd1, 8'd0, "ord_pop2");
      tab[5] = mk(0, 16'h0000, 48'h0, 0, 1, 0, 64'h0,                 4'd0, 8'd0, "ord_pop3");
      tab[6] = mk(1, 16'h0000, 48'h5, 0, 0, 0, 64'h0,                 4'd0, 8'd0, "zf_addr0");
      tab[7] = mk(1, 16'h0007, 48'h0, 0, 0, 0, 64'h0,                 4'd0, 8'd0, "zf_data0");
      tab[8] = mk(1, 16'h0007, 48'h5, 0, 0, 1, 64'h0007_000000000005, 4'd1, 8'd0, "zf_good");
      tab[9] = mk(0, 16'h0000, 48'h0, 1, 0, 0, 64'h0,                 4'd0, 8'd0, "flush1");

      // Reset state, no clock edge needed.
      #3;
      chk_out("reset", 0, 64'h0, 4'd0, 8'd0);
      tick();
      tick();
      reset = 1'b1;

      for (int i = 0; i < 9; i++) begin
         drv(tab[i].iv, tab[i].a, tab[i].d, tab[i].fl, tab[i].rdy);
         tick();
         chk_out(tab[i].nm, tab[i].ev, tab[i].ed, tab[i].el, tab[i].edc);
      end

      // Unfiltered instance buffered all three pairs, oldest first.
      chk("nf_level", 64'(nf_level), 64'd3);
      chk("nf_valid", 64'(nf_valid), 64'd1);
      chk("nf_data",  nf_data, 64'h0000_000000000005);
      chk("nf_full",  64'(nf_full), 64'd0);
      chk("nf_drop",  64'(nf_drop), 64'd0);

      drv(tab[9].iv, tab[9].a, tab[9].d, tab[9].fl, tab[9].rdy);
      tick();
      chk_out(tab[9].nm, tab[9].ev, tab[9].ed, tab[9].el, tab[9].edc);

      // Overflow: fill, drop three, then pop-while-push on a full FIFO.
      for (int i = 0; i < 8; i++) begin
         drv(1, 16'(i + 1), 48'(i + 'h100), 0, 0);
         tick();
      end
      chk("ovf_full", 64'(full), 64'd1);
      chk("ovf_level8", 64'(level), 64'd8);
      for (int i = 0; i < 3; i++) begin
         drv(1, 16'(i + 'h50), 48'h77, 0, 0);
         tick();
         chk("ovf_drop", 64'(drop_count), 64'(i + 1));
      end
      chk("ovf_head", out_data, {16'h0001, 48'h100});
      drv(1, 16'h00AA, 48'hBB, 0, 1);
      tick();
      chk_out("ovf_popfull", 1, {16'h0002, 48'h101}, 4'd8, 8'd3);
      drv(0, 16'h0, 48'h0, 0, 1);
      for (int i = 0; i < 8; i++) begin
         e = (i < 7) ? {16'(i + 2), 48'(i + 'h101)} : {16'h00AA, 48'hBB};
         chk("ovf_drain", out_data, e);
         tick();
      end
      chk_out("ovf_empty", 0, 64'h0, 4'd0, 8'd3);

      // Flush clears the drop counter.
      drv(0, 16'h0, 48'h0, 1, 0);
      tick();
      chk_out("flush2", 0, 64'h0, 4'd0, 8'd0);

      // Wrap-around: one pair per cycle with the consumer always ready.
      for (int k = 0; k < 20; k++) begin
         drv(1, 16'(k + 'h100), 48'(3 * k + 1), 0, 1);
         tick();
         chk("wrap_level", 64'(level), 64'd1);
         if (out_valid) got.push_back(out_data);
      end
      drv(0, 16'h0, 48'h0, 0, 1);
      for (int k = 0; k < 4; k++) begin
         tick();
         if (out_valid) got.push_back(out_data);
      end
      chk("wrap_count", 64'(got.size()), 64'd20);
      for (int k = 0; k < 20 && k < got.size(); k++)
         chk("wrap_item", got[k], {16'(k + 'h100), 48'(3 * k + 1)});
      chk("wrap_drop", 64'(drop_count), 64'd0);
      chk("wrap_empty", 64'(out_valid), 64'd0);

      // Flush with 5 entries and 2 drops, concurrent push ignored.
      for (int i = 0; i < 10; i++) begin
         drv(1, 16'(i + 'h200), 48'(i + 'h9), 0, 0);
         tick();
      end
      drv(0, 16'h0, 48'h0, 0, 1);
      for (int i = 0; i < 3; i++) tick();
      chk_out("pre_flush", 1, {16'h0203, 48'hC}, 4'd5, 8'd2);
      drv(1, 16'h0033, 48'h44, 1, 0);
      tick();
      chk_out("flush_push", 0, 64'h0, 4'd0, 8'd0);
      drv(1, 16'h0033, 48'h44, 0, 0);
      tick();
      chk_out("post_flush", 1, {16'h0033, 48'h44}, 4'd1, 8'd0);

      // Asynchronous reset mid-stream, with a drop recorded.
      for (int i = 0; i < 8; i++) begin
         drv(1, 16'(i + 'h300), 48'(i + 'h1), 0, 0);
         tick();
      end
      chk("pre_rst_drop", 64'(drop_count), 64'd1);
      #2;
      reset = 1'b0;
      #1;
      chk_out("async_rst", 0, 64'h0, 4'd0, 8'd0);
      drv(0, 16'h0, 48'h0, 0, 0);
      tick();
      reset = 1'b1;
      tick();
      chk_out("after_rst", 0, 64'h0, 4'd0, 8'd0);

`ifdef RESULT_STREAM_DEDUP_EN
      for (int i = 0; i < 3; i++) begin
         drv(1, 16'h0005, 48'h9, 0, 0);
         tick();
      end
      drv(1, 16'h0005, 48'hA, 0, 0);
      tick();
      chk_out("dedup", 1, {16'h0005, 48'h9}, 4'd2, 8'd0);
      drv(0, 16'h0, 48'h0, 1, 0);
      tick();
      drv(1, 16'h0005, 48'hA, 0, 0);
      tick();
      chk_out("dedup_flush", 1, {16'h0005, 48'hA}, 4'd1, 8'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
